roi_pixel_stats: RTL and testbench
==================================

# roi_pixel_stats

Downstream stage of the radar ROI pixel extractor. It consumes the `pixel_out` stream framed by `data_start`/`data_end`, and accumulates per-frame statistics: pixel count, sum, peak value, peak index and channel tag. It presents one registered result per frame on a valid/ready handshake to the detection/reporting logic.

## Interface
Parameters:
- `PIXEL_W`, 16: pixel width, unsigned.
- `CNT_W`, 16: pixel-count width.
- `CH_W`, 4: channel tag width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset. One clock; reset is synchronous and active-low.
- `data_start`, in, 1: first pixel of frame on `pixel_in` this cycle.
- `data_end`, in, 1: last pixel of frame on `pixel_in` this cycle.
- `pixel_in`, in, `PIXEL_W`: pixel (upstream `pixel_out`).
- `channel_num`, in, `CH_W`: channel of frame, sampled with `data_start`.
- `stat_valid`, out, 1: result valid.
- `stat_ready`, in, 1: downstream accepts result.
- `stat_count`, out, `CNT_W`: pixels in frame.
- `stat_sum`, out, `CNT_W+PIXEL_W`: sum of pixels.
- `stat_peak`, out, `PIXEL_W`: maximum pixel.
- `stat_peak_idx`, out, `CNT_W`: zero-based index of first maximum.
- `stat_channel`, out, `CH_W`: captured channel.
- `stat_ovf`, out, 1: count saturated in this frame.
- `frame_drop`, out, 1: one-cycle pulse, frame discarded.
- `busy`, out, 1: FSM not IDLE.

## Operation
- FSM states: IDLE, ACCUM, HOLD. State enum lives in the package.
- Pixels are valid on every cycle from `data_start` through `data_end` inclusive. There is no separate valid signal.
- IDLE + `data_start`:
  - load count=1, sum=pixel, peak=pixel, peak_idx=0, channel=`channel_num`.
  - go to ACCUM, or straight to HOLD if `data_end` is also high (single-pixel frame).
- ACCUM, per cycle:
  - count+1, saturating at all-ones; saturation sets ovf, sticky for the frame.
  - sum += pixel. Sum is full width and cannot wrap for ≤2^CNT_W pixels.
  - if pixel > peak (strict, unsigned): peak=pixel, peak_idx=pre-increment count. Ties keep the earlier index.
- ACCUM + `data_end`: include the pixel, latch results to the output registers, go to HOLD.
- ACCUM + `data_start` (restart without end): discard partial frame, pulse `frame_drop`, start a new frame with this pixel.
- HOLD: `stat_valid`=1, outputs stable until `stat_valid && stat_ready`.
  - handshake: go to IDLE.
  - handshake with `data_start` in the same cycle: the new frame is accepted; go to ACCUM (or HOLD if `data_end` is also high).
  - `data_start` without handshake: the whole incoming frame is ignored through its `data_end`, and `frame_drop` pulses once at its `data_start`.
- `data_end` in IDLE (no open frame) is ignored.

## Timing
- Reset values: `stat_valid`=0, all stat outputs=0, `frame_drop`=0, `busy`=0, state IDLE.
- Reset mid-frame or mid-HOLD discards everything. The next cycle is IDLE.
- `stat_valid` rises on the cycle after `data_end` is sampled (latency 1).
- `stat_valid` falls on the cycle after the handshake.
- Back-to-back frames (`data_end` at cycle N, `data_start` at N+1) are accepted only if the result is taken at N+1.
- `frame_drop` is registered and asserts the cycle after the offending `data_start`.

## Configuration
- `ROI_STATS_THRESH_EN` defined:
  - adds parameter `THRESH`, default 16'h0100.
  - adds output `stat_above`, `CNT_W`: count of pixels strictly greater than `THRESH`, saturating, same timing as `stat_count`.
- Undefined: no port, no logic.

## Structure
- Package `radar_stats_pkg`: state enum typedef, and the `SUM_W` width function/localparam.
- One sub-module `roi_frame_accum` holds the count/sum/peak/threshold datapath, with load/accumulate controls. The FSM, handshake and drop logic stay in the top module.

## Test plan
- Frame 5,9,3,9,1 on channel 2, `stat_ready`=1 → after 1 cycle: count=5, sum=27, peak=9, idx=1, channel=2, ovf=0.
- Single-pixel frame (start+end same cycle), pixel 7 → count=1, sum=7, peak=7, idx=0. `stat_valid` on the next cycle.
- Hold `stat_ready`=0 for 10 cycles, then send a second frame → outputs stable, `frame_drop` pulses once, the second frame is never reported. The first result is delivered after `stat_ready`=1.
- Handshake and `data_start` in the same cycle, frames 1,2 then 4,4 → two results: (2,3,2,1) then (2,8,4,0).
- `data_start` at pixel 3 of an open frame, then `rst_n`=0 mid-frame → `frame_drop` on restart; after reset all outputs are 0 and no result is emitted.
- With `ROI_STATS_THRESH_EN` and THRESH=8: frame 5,9,3,12 → `stat_above`=2. With CNT_W=3 and 9 pixels: count=7, ovf=1.

Source files
------------

// File: rtl/radar_stats_pkg.sv
// Shared types and widths for the ROI pixel statistics block.
// Holds the control FSM state encoding and the sum-width helper.
// No logic; imported by roi_frame_accum and roi_pixel_stats.
package radar_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Sum is wide enough that it cannot wrap for up to 2^cnt_w pixels.
    function automatic int sum_w(input int cnt_w, input int pixel_w);
        return cnt_w + pixel_w;
    endfunction

    localparam int SUM_W = sum_w(16, 16);

endpackage

// File: rtl/roi_frame_accum.sv
// Per-frame datapath: pixel count, sum, peak, peak index, channel (and above-threshold count).
// Latency 0 on nxt_* (value after this cycle's load/accumulate); working registers update at the edge.
// No backpressure; load/accum are driven by the control FSM. Optional: ROI_STATS_THRESH_EN.
module roi_frame_accum import radar_stats_pkg::*; #(
    parameter int PIXEL_W = 16,
    parameter int CNT_W   = 16,
    parameter int CH_W    = 4
`ifdef ROI_STATS_THRESH_EN
    , parameter logic [PIXEL_W-1:0] THRESH = PIXEL_W'(16'h0100)
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 load,
    input  logic                                 accum,
    input  logic [PIXEL_W-1:0]                   pixel_in,
    input  logic [CH_W-1:0]                      channel_in,
    output logic [CNT_W-1:0]                     nxt_count,
    output logic [sum_w(CNT_W, PIXEL_W)-1:0]     nxt_sum,
    output logic [PIXEL_W-1:0]                   nxt_peak,
    output logic [CNT_W-1:0]                     nxt_peak_idx,
    output logic [CH_W-1:0]                      nxt_channel,
`ifdef ROI_STATS_THRESH_EN
    output logic [CNT_W-1:0]                     nxt_above,
`endif
    output logic                                 nxt_ovf
);

    localparam int SW = sum_w(CNT_W, PIXEL_W);

    logic [CNT_W-1:0]   count_q, count_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [PIXEL_W-1:0] peak_q, peak_d;
    logic [CNT_W-1:0]   peak_idx_q, peak_idx_d;
    logic [CH_W-1:0]    channel_q, channel_d;
    logic               ovf_q, ovf_d;
`ifdef ROI_STATS_THRESH_EN
    logic [CNT_W-1:0]   above_q, above_d;
`endif

    // Load starts a fresh frame from this pixel; accumulate folds this pixel into the running stats.
    always_comb begin
        count_d    = count_q;
        sum_d      = sum_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        channel_d  = channel_q;
        ovf_d      = ovf_q;
`ifdef ROI_STATS_THRESH_EN
        above_d    = above_q;
`endif
        if (load) begin
            count_d    = CNT_W'(1);
            sum_d      = SW'(pixel_in);
            peak_d     = pixel_in;
            peak_idx_d = '0;
            channel_d  = channel_in;
            ovf_d      = 1'b0;
`ifdef ROI_STATS_THRESH_EN
            above_d    = (pixel_in > THRESH) ? CNT_W'(1) : '0;
`endif
        end else if (accum) begin
            // Count saturates at all-ones; hitting the ceiling marks the frame overflowed.
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            sum_d = sum_q + SW'(pixel_in);
            // Strict compare so ties keep the earliest index; index is the pre-increment count.
            if (pixel_in > peak_q) begin
                peak_d     = pixel_in;
                peak_idx_d = count_q;
            end
`ifdef ROI_STATS_THRESH_EN
            if ((pixel_in > THRESH) && !(&above_q)) begin
                above_d = above_q + 1'b1;
            end
`endif
        end
    end

    // Working registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            sum_q      <= '0;
            peak_q     <= '0;
            peak_idx_q <= '0;
            channel_q  <= '0;
            ovf_q      <= 1'b0;
`ifdef ROI_STATS_THRESH_EN
            above_q    <= '0;
`endif
        end else begin
            count_q    <= count_d;
            sum_q      <= sum_d;
            peak_q     <= peak_d;
            peak_idx_q <= peak_idx_d;
            channel_q  <= channel_d;
            ovf_q      <= ovf_d;
`ifdef ROI_STATS_THRESH_EN
            above_q    <= above_d;
`endif
        end
    end

    assign nxt_count    = count_d;
    assign nxt_sum      = sum_d;
    assign nxt_peak     = peak_d;
    assign nxt_peak_idx = peak_idx_d;
    assign nxt_channel  = channel_d;
    assign nxt_ovf      = ovf_d;
`ifdef ROI_STATS_THRESH_EN
    assign nxt_above    = above_d;
`endif

endmodule

// File: rtl/roi_pixel_stats.sv
// Per-frame ROI pixel statistics with one registered result per frame on stat_valid/stat_ready.
// Latency: stat_valid rises the cycle after data_end is sampled.
// Backpressure: while a result is held, new frames are dropped (frame_drop pulse). Optional: ROI_STATS_THRESH_EN.
module roi_pixel_stats import radar_stats_pkg::*; #(
    parameter int PIXEL_W = 16,
    parameter int CNT_W   = 16,
    parameter int CH_W    = 4
`ifdef ROI_STATS_THRESH_EN
    , parameter logic [PIXEL_W-1:0] THRESH = PIXEL_W'(16'h0100)
`endif
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              data_start,
    input  logic                              data_end,
    input  logic [PIXEL_W-1:0]                pixel_in,
    input  logic [CH_W-1:0]                   channel_num,
    output logic                              stat_valid,
    input  logic                              stat_ready,
    output logic [CNT_W-1:0]                  stat_count,
    output logic [sum_w(CNT_W, PIXEL_W)-1:0]  stat_sum,
    output logic [PIXEL_W-1:0]                stat_peak,
    output logic [CNT_W-1:0]                  stat_peak_idx,
    output logic [CH_W-1:0]                   stat_channel,
    output logic                              stat_ovf,
    output logic                              frame_drop,
`ifdef ROI_STATS_THRESH_EN
    output logic [CNT_W-1:0]                  stat_above,
`endif
    output logic                              busy
);

    localparam int SW = sum_w(CNT_W, PIXEL_W);

    state_e state_q, state_d;
    logic   drop_q, drop_d;
    logic   load, accum, latch, hs;

    logic [CNT_W-1:0]   nxt_count, nxt_peak_idx;
    logic [SW-1:0]      nxt_sum;
    logic [PIXEL_W-1:0] nxt_peak;
    logic [CH_W-1:0]    nxt_channel;
    logic               nxt_ovf;

    logic [CNT_W-1:0]   count_q, count_d, peak_idx_q, peak_idx_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [PIXEL_W-1:0] peak_q, peak_d;
    logic [CH_W-1:0]    channel_q, channel_d;
    logic               ovf_q, ovf_d;
`ifdef ROI_STATS_THRESH_EN
    logic [CNT_W-1:0]   nxt_above, above_q, above_d;
`endif

    roi_frame_accum #(
        .PIXEL_W (PIXEL_W),
        .CNT_W   (CNT_W),
        .CH_W    (CH_W)
`ifdef ROI_STATS_THRESH_EN
        , .THRESH(THRESH)
`endif
    ) u_accum (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .accum        (accum),
        .pixel_in     (pixel_in),
        .channel_in   (channel_num),
        .nxt_count    (nxt_count),
        .nxt_sum      (nxt_sum),
        .nxt_peak     (nxt_peak),
        .nxt_peak_idx (nxt_peak_idx),
        .nxt_channel  (nxt_channel),
`ifdef ROI_STATS_THRESH_EN
        .nxt_above    (nxt_above),
`endif
        .nxt_ovf      (nxt_ovf)
    );

    // Control FSM: frame open/close, restart drop, and hold-until-handshake.
    always_comb begin
        state_d = state_q;
        drop_d  = 1'b0;
        load    = 1'b0;
        accum   = 1'b0;
        latch   = 1'b0;
        hs      = (state_q == ST_HOLD) && stat_ready;
        case (state_q)
            ST_IDLE: begin
                if (data_start) begin
                    load    = 1'b1;
                    latch   = data_end;
                    state_d = data_end ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (data_start) begin
                    // Restart without end: partial frame is thrown away.
                    load    = 1'b1;
                    drop_d  = 1'b1;
                    latch   = data_end;
                    state_d = data_end ? ST_HOLD : ST_ACCUM;
                end else begin
                    accum = 1'b1;
                    if (data_end) begin
                        latch   = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (hs) begin
                    if (data_start) begin
                        load    = 1'b1;
                        latch   = data_end;
                        state_d = data_end ? ST_HOLD : ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (data_start) begin
                    // Result still pending: the incoming frame is ignored; remaining pixels fall
                    // through HOLD/IDLE without effect.
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers capture the completed frame's stats on the closing cycle.
    always_comb begin
        count_d    = count_q;
        sum_d      = sum_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        channel_d  = channel_q;
        ovf_d      = ovf_q;
`ifdef ROI_STATS_THRESH_EN
        above_d    = above_q;
`endif
        if (latch) begin
            count_d    = nxt_count;
            sum_d      = nxt_sum;
            peak_d     = nxt_peak;
            peak_idx_d = nxt_peak_idx;
            channel_d  = nxt_channel;
            ovf_d      = nxt_ovf;
`ifdef ROI_STATS_THRESH_EN
            above_d    = nxt_above;
`endif
        end
    end

    // State, drop pulse and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            drop_q     <= 1'b0;
            count_q    <= '0;
            sum_q      <= '0;
            peak_q     <= '0;
            peak_idx_q <= '0;
            channel_q  <= '0;
            ovf_q      <= 1'b0;
`ifdef ROI_STATS_THRESH_EN
            above_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            peak_q     <= peak_d;
            peak_idx_q <= peak_idx_d;
            channel_q  <= channel_d;
            ovf_q      <= ovf_d;
`ifdef ROI_STATS_THRESH_EN
            above_q    <= above_d;
`endif
        end
    end

    assign stat_valid    = (state_q == ST_HOLD);
    assign busy          = (state_q != ST_IDLE);
    assign frame_drop    = drop_q;
    assign stat_count    = count_q;
    assign stat_sum      = sum_q;
    assign stat_peak     = peak_q;
    assign stat_peak_idx = peak_idx_q;
    assign stat_channel  = channel_q;
    assign stat_ovf      = ovf_q;
`ifdef ROI_STATS_THRESH_EN
    assign stat_above    = above_q;
`endif

endmodule

// File: tb/tb_roi_pixel_stats.sv
// Directed bench for roi_pixel_stats: main instance at default widths, second instance with CNT_W=3.
// Inputs driven #1 after the rising edge; outputs checked #1 after the following edge.
// Threshold test only when ROI_STATS_THRESH_EN is defined.
module tb_roi_pixel_stats;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_start, data_end, stat_ready;
    logic [15:0] pixel_in;
    logic [3:0]  channel_num;
    logic        stat_valid, stat_ovf, frame_drop, busy;
    logic [15:0] stat_count, stat_peak, stat_peak_idx;
    logic [31:0] stat_sum;
    logic [3:0]  stat_channel;
`ifdef ROI_STATS_THRESH_EN
    logic [15:0] stat_above;
`endif

    // Small-counter instance
    logic        s_start, s_end, s_ready;
    logic [15:0] s_pix;
    logic [3:0]  s_ch;
    logic        s_valid, s_ovf, s_drop, s_busy;
    logic [2:0]  s_count, s_idx;
    logic [18:0] s_sum;
    logic [15:0] s_peak;
    logic [3:0]  s_chan;
`ifdef ROI_STATS_THRESH_EN
    logic [2:0]  s_above;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    roi_pixel_stats #(
        .PIXEL_W(16), .CNT_W(16), .CH_W(4)
`ifdef ROI_STATS_THRESH_EN
        , .THRESH(16'd8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_start(data_start), .data_end(data_end),
        .pixel_in(pixel_in), .channel_num(channel_num), .stat_valid(stat_valid),
        .stat_ready(stat_ready), .stat_count(stat_count), .stat_sum(stat_sum),
        .stat_peak(stat_peak), .stat_peak_idx(stat_peak_idx), .stat_channel(stat_channel),
        .stat_ovf(stat_ovf), .frame_drop(frame_drop),
`ifdef ROI_STATS_THRESH_EN
        .stat_above(stat_above),
`endif
        .busy(busy)
    );

    roi_pixel_stats #(.PIXEL_W(16), .CNT_W(3), .CH_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .data_start(s_start), .data_end(s_end),
        .pixel_in(s_pix), .channel_num(s_ch), .stat_valid(s_valid),
        .stat_ready(s_ready), .stat_count(s_count), .stat_sum(s_sum),
        .stat_peak(s_peak), .stat_peak_idx(s_idx), .stat_channel(s_chan),
        .stat_ovf(s_ovf), .frame_drop(s_drop),
`ifdef ROI_STATS_THRESH_EN
        .stat_above(s_above),
`endif
        .busy(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic en, input logic [15:0] pix, input logic [3:0] ch);
        data_start  = st;
        data_end    = en;
        pixel_in    = pix;
        channel_num = ch;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stat_ready = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 4'd0);
        s_start = 1'b0; s_end = 1'b0; s_pix = '0; s_ch = '0; s_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (stat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", stat_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", frame_drop); end
        n_checks++;
        if ({stat_count, stat_sum, stat_peak, stat_peak_idx, stat_channel, stat_ovf} !== 85'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got cnt=%0d sum=%0d peak=%0d idx=%0d ch=%0d ovf=%b expected all 0",
                     stat_count, stat_sum, stat_peak, stat_peak_idx, stat_channel, stat_ovf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        stat_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd5, 4'd2); tick();
        n_checks++;
        if (busy !== 1'b1 || stat_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy: got busy=%b valid=%b expected busy=1 valid=0", busy, stat_valid);
        end
        drive(1'b0, 1'b0, 16'd9, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd3, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd9, 4'd0); tick();
        drive(1'b0, 1'b1, 16'd1, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd0, 4'd0);
        n_checks++;
        if (stat_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", stat_valid); end
        n_checks++;
        if (stat_count !== 16'd5 || stat_sum !== 32'd27 || stat_peak !== 16'd9 || stat_peak_idx !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_stats: got cnt=%0d sum=%0d peak=%0d idx=%0d expected 5 27 9 1",
                     stat_count, stat_sum, stat_peak, stat_peak_idx);
        end
        n_checks++;
        if (stat_channel !== 4'd2 || stat_ovf !== 1'b0 || frame_drop !== 1'b0) begin
            n_fail++; $display("FAIL basic_ch_ovf: got ch=%0d ovf=%b drop=%b expected 2 0 0", stat_channel, stat_ovf, frame_drop);
        end
        tick();
        n_checks++;
        if (stat_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_release: got valid=%b busy=%b expected 0 0", stat_valid, busy);
        end
    endtask

    task automatic test_single_pixel();
        stat_ready = 1'b0;
        drive(1'b1, 1'b1, 16'd7, 4'd6); tick();
        drive(1'b0, 1'b0, 16'd0, 4'd0);
        n_checks++;
        if (stat_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", stat_valid); end
        n_checks++;
        if (stat_count !== 16'd1 || stat_sum !== 32'd7 || stat_peak !== 16'd7 || stat_peak_idx !== 16'd0 || stat_channel !== 4'd6) begin
            n_fail++;
            $display("FAIL single_stats: got cnt=%0d sum=%0d peak=%0d idx=%0d ch=%0d expected 1 7 7 0 6",
                     stat_count, stat_sum, stat_peak, stat_peak_idx, stat_channel);
        end
        stat_ready = 1'b1;
        tick();
        n_checks++;
        if (stat_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b expected 0", stat_valid); end
    endtask

    task automatic test_hold_drop();
        int drops;
        int late_valid;
        logic stable;
        stat_ready = 1'b0;
        drive(1'b1, 1'b0, 16'd10, 4'd3); tick();
        drive(1'b0, 1'b1, 16'd20, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd0, 4'd0);
        n_checks++;
        if (stat_valid !== 1'b1 || stat_count !== 16'd2 || stat_sum !== 32'd30 || stat_peak !== 16'd20 ||
            stat_peak_idx !== 16'd1 || stat_channel !== 4'd3) begin
            n_fail++;
            $display("FAIL hold_first: got v=%b cnt=%0d sum=%0d peak=%0d idx=%0d ch=%0d expected 1 2 30 20 1 3",
                     stat_valid, stat_count, stat_sum, stat_peak, stat_peak_idx, stat_channel);
        end
        drops = 0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3)      drive(1'b1, 1'b0, 16'd50, 4'd7);
            else if (i == 4) drive(1'b0, 1'b0, 16'd60, 4'd0);
            else if (i == 5) drive(1'b0, 1'b1, 16'd70, 4'd0);
            else             drive(1'b0, 1'b0, 16'd0, 4'd0);
            tick();
            if (frame_drop === 1'b1) drops++;
            if (stat_valid !== 1'b1 || stat_count !== 16'd2 || stat_sum !== 32'd30 || stat_peak !== 16'd20 ||
                stat_channel !== 4'd3) stable = 1'b0;
        end
        n_checks++;
        if (drops != 1) begin n_fail++; $display("FAIL hold_drop_count: got %0d pulses expected 1", drops); end
        n_checks++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got outputs changed during stall expected stable"); end
        stat_ready = 1'b1;
        tick();
        late_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (stat_valid === 1'b1) late_valid++;
            tick();
        end
        n_checks++;
        if (late_valid != 0) begin n_fail++; $display("FAIL hold_dropped_reported: got %0d valid cycles expected 0", late_valid); end
    endtask

    task automatic test_back_to_back();
        stat_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd1, 4'd1); tick();
        drive(1'b0, 1'b1, 16'd2, 4'd0); tick();
        n_checks++;
        if (stat_valid !== 1'b1 || {stat_count, stat_sum, stat_peak, stat_peak_idx} !== {16'd2, 32'd3, 16'd2, 16'd1}) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b cnt=%0d sum=%0d peak=%0d idx=%0d expected 1 2 3 2 1",
                     stat_valid, stat_count, stat_sum, stat_peak, stat_peak_idx);
        end
        drive(1'b1, 1'b0, 16'd4, 4'd1); tick();
        n_checks++;
        if (stat_valid !== 1'b0 || busy !== 1'b1 || frame_drop !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got v=%b busy=%b drop=%b expected 0 1 0", stat_valid, busy, frame_drop);
        end
        drive(1'b0, 1'b1, 16'd4, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd0, 4'd0);
        n_checks++;
        if (stat_valid !== 1'b1 || {stat_count, stat_sum, stat_peak, stat_peak_idx} !== {16'd2, 32'd8, 16'd4, 16'd0}) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%b cnt=%0d sum=%0d peak=%0d idx=%0d expected 1 2 8 4 0",
                     stat_valid, stat_count, stat_sum, stat_peak, stat_peak_idx);
        end
        tick();
    endtask

    task automatic test_restart_reset();
        int seen;
        stat_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd1, 4'd5); tick();
        drive(1'b0, 1'b0, 16'd2, 4'd0); tick();
        drive(1'b1, 1'b0, 16'd3, 4'd5); tick();
        n_checks++;
        if (frame_drop !== 1'b1) begin n_fail++; $display("FAIL restart_drop: got %b expected 1", frame_drop); end
        drive(1'b0, 1'b0, 16'd4, 4'd0); tick();
        n_checks++;
        if (frame_drop !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_pulse_width: got drop=%b busy=%b expected 0 1", frame_drop, busy);
        end
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'd6, 4'd0); tick();
        n_checks++;
        if (stat_valid !== 1'b0 || busy !== 1'b0 || frame_drop !== 1'b0 ||
            {stat_count, stat_sum, stat_peak, stat_peak_idx, stat_channel, stat_ovf} !== 85'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got v=%b busy=%b cnt=%0d sum=%0d peak=%0d ch=%0d expected all 0",
                     stat_valid, busy, stat_count, stat_sum, stat_peak, stat_channel);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 16'd5, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd0, 4'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (stat_valid === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL reset_no_result: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_saturation();
        s_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_start = (i == 0); s_end = (i == 6); s_pix = 16'd1;
            tick();
        end
        s_start = 1'b0; s_end = 1'b0; s_pix = '0;
        n_checks++;
        if (s_valid !== 1'b1 || s_count !== 3'd7 || s_ovf !== 1'b0 || s_sum !== 19'd7) begin
            n_fail++; $display("FAIL sat_edge: got v=%b cnt=%0d ovf=%b sum=%0d expected 1 7 0 7", s_valid, s_count, s_ovf, s_sum);
        end
        tick();
        for (int i = 0; i < 9; i++) begin
            s_start = (i == 0); s_end = (i == 8); s_pix = 16'(i + 1);
            tick();
        end
        s_start = 1'b0; s_end = 1'b0; s_pix = '0;
        n_checks++;
        if (s_valid !== 1'b1 || s_count !== 3'd7 || s_ovf !== 1'b1 || s_sum !== 19'd45 || s_peak !== 16'd9) begin
            n_fail++;
            $display("FAIL sat_ovf: got v=%b cnt=%0d ovf=%b sum=%0d peak=%0d expected 1 7 1 45 9",
                     s_valid, s_count, s_ovf, s_sum, s_peak);
        end
        tick();
    endtask

`ifdef ROI_STATS_THRESH_EN
    task automatic test_thresh();
        stat_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd5, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd9, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd3, 4'd0); tick();
        drive(1'b0, 1'b1, 16'd12, 4'd0); tick();
        drive(1'b0, 1'b0, 16'd0, 4'd0);
        n_checks++;
        if (stat_valid !== 1'b1 || stat_above !== 16'd2 || stat_count !== 16'd4) begin
            n_fail++; $display("FAIL thresh_above: got v=%b above=%0d cnt=%0d expected 1 2 4", stat_valid, stat_above, stat_count);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_single_pixel();
        test_hold_drop();
        test_back_to_back();
        test_restart_reset();
        test_saturation();
`ifdef ROI_STATS_THRESH_EN
        test_thresh();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
